// File: rtl/bridge_pkg.sv
// Shared types for the NoC-to-AXI bridge endpoints.
// Holds the FSM encoding, response codes and packet field widths.
package bridge_pkg;

    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_DATA_WIDTH  = 32;
    localparam int AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_SEND
    } state_t;

endpackage

// File: rtl/if_axi_light.sv
// Single-beat AXI-light bus: AW, W, B, AR and R channels.
// The master modport is used by bridge_master.
interface if_axi_light;
    import bridge_pkg::*;

    logic                       awvalid;
    logic                       awready;
    logic [AXI_ADDR_WIDTH-1:0]  awaddr;
    logic                       wvalid;
    logic                       wready;
    logic [AXI_DATA_WIDTH-1:0]  wdata;
    logic [AXI_WSTRB_WIDTH-1:0] wstrb;
    logic                       bvalid;
    logic                       bready;
    resp_t                      bresp;
    logic                       arvalid;
    logic                       arready;
    logic [AXI_ADDR_WIDTH-1:0]  araddr;
    logic                       rvalid;
    logic                       rready;
    logic [AXI_DATA_WIDTH-1:0]  rdata;
    resp_t                      rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/bridge_master.sv
// Memory-side NoC endpoint: replays one request packet as one AXI-light
// transaction and returns one response packet; one transaction in flight.
module bridge_master
    import bridge_pkg::*;
#(
    parameter int ID       = 0,
    parameter int ID_WIDTH = 8,
    parameter int TIMEOUT  = 0
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ID_WIDTH-1:0]        req_src,
    input  logic                       req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [AXI_WSTRB_WIDTH-1:0] req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_WIDTH-1:0]        rsp_dst,
    output logic [ID_WIDTH-1:0]        rsp_src,
    output logic                       rsp_we,
    output logic [31:0]                rsp_rdata,
    output logic [1:0]                 rsp_resp,
    if_axi_light.master                m_axi
);

    state_t                       state, state_nxt;
    logic                         rdy_nxt;
    logic                         aw_q, aw_nxt;
    logic                         w_q, w_nxt;
    logic                         ar_q, ar_nxt;
    logic                         b_q, b_nxt;
    logic                         r_q, r_nxt;
    logic                         rsp_q, rsp_nxt;
    logic [ID_WIDTH-1:0]          src_q, src_nxt;
    logic                         we_q, we_nxt;
    logic [AXI_ADDR_WIDTH-1:0]    addr_q, addr_nxt;
    logic [31:0]                  wdata_q, wdata_nxt;
    logic [AXI_WSTRB_WIDTH-1:0]   wstrb_q, wstrb_nxt;
    logic [31:0]                  rdata_q, rdata_nxt;
    resp_t                        resp_q, resp_nxt;
    logic [31:0]                  cnt, cnt_nxt;
    logic                         expired;

    // Expiry is only consulted when no real completion arrived this cycle.
    assign expired = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        rdy_nxt   = 1'b0;
        aw_nxt    = aw_q;
        w_nxt     = w_q;
        ar_nxt    = ar_q;
        b_nxt     = b_q;
        r_nxt     = r_q;
        rsp_nxt   = rsp_q;
        src_nxt   = src_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        wstrb_nxt = wstrb_q;
        rdata_nxt = rdata_q;
        resp_nxt  = resp_q;
        cnt_nxt   = cnt + 32'd1;
        unique case (state)
            S_IDLE: begin
                rdy_nxt = 1'b1;
                cnt_nxt = '0;
                if (req_valid && req_ready) begin
                    rdy_nxt   = 1'b0;
                    src_nxt   = req_src;
                    we_nxt    = req_we;
                    addr_nxt  = req_addr;
                    wdata_nxt = req_wdata;
                    wstrb_nxt = req_wstrb;
                    if (req_we) begin
                        state_nxt = S_WR;
                        aw_nxt    = 1'b1;
                        w_nxt     = 1'b1;
                    end else begin
                        state_nxt = S_RD_ADDR;
                        ar_nxt    = 1'b1;
                    end
                end
            end
            S_WR: begin
                aw_nxt = aw_q & ~m_axi.awready;
                w_nxt  = w_q & ~m_axi.wready;
                if (!aw_nxt && !w_nxt) begin
                    state_nxt = S_WR_RESP;
                    b_nxt     = 1'b1;
                end else if (expired) begin
                    aw_nxt    = 1'b0;
                    w_nxt     = 1'b0;
                    rsp_nxt   = 1'b1;
                    rdata_nxt = '0;
                    resp_nxt  = RESP_SLVERR;
                    state_nxt = S_SEND;
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid) begin
                    b_nxt     = 1'b0;
                    rsp_nxt   = 1'b1;
                    rdata_nxt = '0;
                    resp_nxt  = m_axi.bresp;
                    state_nxt = S_SEND;
                end else if (expired) begin
                    b_nxt     = 1'b0;
                    rsp_nxt   = 1'b1;
                    rdata_nxt = '0;
                    resp_nxt  = RESP_SLVERR;
                    state_nxt = S_SEND;
                end
            end
            S_RD_ADDR: begin
                if (m_axi.arready) begin
                    ar_nxt    = 1'b0;
                    r_nxt     = 1'b1;
                    state_nxt = S_RD_DATA;
                end else if (expired) begin
                    ar_nxt    = 1'b0;
                    rsp_nxt   = 1'b1;
                    rdata_nxt = '0;
                    resp_nxt  = RESP_SLVERR;
                    state_nxt = S_SEND;
                end
            end
            S_RD_DATA: begin
                if (m_axi.rvalid) begin
                    r_nxt     = 1'b0;
                    rsp_nxt   = 1'b1;
                    rdata_nxt = m_axi.rdata;
                    resp_nxt  = m_axi.rresp;
                    state_nxt = S_SEND;
                end else if (expired) begin
                    r_nxt     = 1'b0;
                    rsp_nxt   = 1'b1;
                    rdata_nxt = '0;
                    resp_nxt  = RESP_SLVERR;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                cnt_nxt = cnt;
                if (rsp_ready) begin
                    rsp_nxt   = 1'b0;
                    rdy_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            aw_q      <= 1'b0;
            w_q       <= 1'b0;
            ar_q      <= 1'b0;
            b_q       <= 1'b0;
            r_q       <= 1'b0;
            rsp_q     <= 1'b0;
            src_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= rdy_nxt;
            aw_q      <= aw_nxt;
            w_q       <= w_nxt;
            ar_q      <= ar_nxt;
            b_q       <= b_nxt;
            r_q       <= r_nxt;
            rsp_q     <= rsp_nxt;
            src_q     <= src_nxt;
            we_q      <= we_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            wstrb_q   <= wstrb_nxt;
            rdata_q   <= rdata_nxt;
            resp_q    <= resp_nxt;
            cnt       <= cnt_nxt;
        end
    end

    assign m_axi.awvalid = aw_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.wvalid  = w_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = b_q;
    assign m_axi.arvalid = ar_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.rready  = r_q;

    assign rsp_valid = rsp_q;
    assign rsp_dst   = src_q;
    assign rsp_src   = ID_WIDTH'(ID);
    assign rsp_we    = we_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_bridge_master.sv
// Bench for bridge_master: scoreboard of expected response packets from a
// word-memory model, behavioural AXI slave with programmable latency.
module tb_bridge_master;
    import bridge_pkg::*;

    localparam int ID = 42;
    localparam int IW = 8;
    localparam int TO = 16;

    logic        clk, res_n;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_src;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [7:0]  rsp_dst, rsp_src;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    if_axi_light axi();

    bridge_master #(.ID(ID), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .res_n(res_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dst(rsp_dst),
        .rsp_src(rsp_src), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .m_axi(axi)
    );

    typedef struct packed {
        logic [7:0]  dst;
        logic        we;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cyc, rise_cyc;
    bit          hold;
    int          flush_req;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          hang_r;
    int          b_count;
    int          exp_b;
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Unwritten memory words read back as a fixed address-derived pattern.
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return 32'h5A00_0000 | {16'h0, a[15:0]};
    endfunction

    // The slave reports SLVERR for the 0x200-aligned error window.
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[9] ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_init(a);
    endfunction

    // ---------------- behavioural AXI slave ----------------
    bit          aw_got, w_got, ar_got, aw_seen, w_seen, b_seen, ar_seen, r_seen;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int          aw_t, w_t, b_t, ar_t, r_t, flush_seen;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_old;
    logic [3:0]  s_wstrb;

    initial begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        flush_seen = 0;
        forever begin
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            b_hs  = axi.bvalid && axi.bready;
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            if (aw_hs) s_awaddr = axi.awaddr;
            if (w_hs) begin s_wdata = axi.wdata; s_wstrb = axi.wstrb; end
            if (ar_hs) s_araddr = axi.araddr;
            @(posedge clk);
            #1;
            if (flush_req != flush_seen) begin
                flush_seen = flush_req;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
            end else begin
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (ar_hs) ar_got = 1;
                if (b_hs) begin
                    s_old = smem.exists(s_awaddr) ? smem[s_awaddr] : mem_init(s_awaddr);
                    smem[s_awaddr] = merge(s_old, s_wdata, s_wstrb);
                    b_count++;
                    aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
                end
                if (r_hs) begin
                    ar_got = 0; ar_seen = 0; r_seen = 0;
                end
            end
            if (axi.awvalid && !aw_seen) begin aw_seen = 1; aw_t = cyc; end
            if (axi.wvalid && !w_seen) begin w_seen = 1; w_t = cyc; end
            if (axi.arvalid && !ar_seen) begin ar_seen = 1; ar_t = cyc; end
            if (aw_got && w_got && !b_seen) begin b_seen = 1; b_t = cyc; end
            if (ar_got && !r_seen) begin r_seen = 1; r_t = cyc; end
            axi.awready = axi.awvalid && !aw_got && (cyc - aw_t >= aw_dly);
            axi.wready  = axi.wvalid && !w_got && (cyc - w_t >= w_dly);
            axi.bvalid  = aw_got && w_got && (cyc - b_t >= b_dly);
            axi.bresp   = resp_of(s_awaddr);
            axi.arready = axi.arvalid && !ar_got && (cyc - ar_t >= ar_dly);
            axi.rvalid  = ar_got && !hang_r && (cyc - r_t >= r_dly);
            axi.rdata   = smem.exists(s_araddr) ? smem[s_araddr] : mem_init(s_araddr);
            axi.rresp   = resp_of(s_araddr);
        end
    end

    // ---------------- response sink and scoreboard monitor ----------------
    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    rsp_t seen, held, e;
    bit   prev_hold, prev_valid;

    always @(negedge clk) begin
        if (!res_n) begin
            prev_hold  = 0;
            prev_valid = 0;
        end else begin
            seen = {rsp_dst, rsp_we, rsp_rdata, rsp_resp};
            if (prev_hold) check("rsp_stable", 64'(seen), 64'(held));
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            if (rsp_valid) check("rsp_src", 64'(rsp_src), 64'(ID));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected got dst %0h expected none", rsp_dst);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_dst", 64'(rsp_dst), 64'(e.dst));
                    check("rsp_we", 64'(rsp_we), 64'(e.we));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                end
            end
            prev_hold  = rsp_valid && !rsp_ready;
            held       = seen;
            prev_valid = rsp_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] src, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit to, input bit track);
        int n;
        rsp_t x;
        @(posedge clk);
        #1;
        req_valid = 1; req_src = src; req_we = we;
        req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 300);
        if (!req_ready) begin
            check("req_accept", 64'(req_ready), 64'd1);
            req_valid = 0;
            return;
        end
        hs_cyc = cyc;
        if (track) begin
            if (to) begin
                x = {src, we, 32'h0, 2'b10};
            end else if (we) begin
                model_mem[addr] = merge(model_rd(addr), wdata, wstrb);
                x = {src, 1'b1, 32'h0, resp_of(addr)};
                exp_b++;
            end else begin
                x = {src, 1'b0, model_rd(addr), resp_of(addr)};
            end
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !rsp_valid) && n < 300);
        if (n >= 300) check("wait_done_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_dly(input int a, input int w, input int b,
                           input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    int          b0;
    logic        rwe;
    logic [31:0] raddr;

    initial begin
        res_n = 0; req_valid = 0; req_src = 0; req_we = 0;
        req_addr = 0; req_wdata = 0; req_wstrb = 0;
        hold = 0; hang_r = 0; flush_req = 0; b_count = 0; exp_b = 0;
        set_dly(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("reset_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid,
              axi.bready, axi.rready, rsp_valid, req_ready}), 64'd0);
        check("reset_fields", 64'({rsp_dst, rsp_we, rsp_rdata, rsp_resp}), 64'd0);
        @(posedge clk);
        #1 res_n = 1;
        @(negedge clk);
        check("req_ready_before_clk", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("req_ready_after_rst", 64'(req_ready), 64'd1);

        // zero-wait write
        send(8'd3, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 1);
        @(negedge clk);
        check("aw_w_cycle1", 64'({axi.awvalid, axi.wvalid}), 64'b11);
        wait_done();
        check("wr_latency", 64'(rise_cyc - hs_cyc), 64'd3);

        // read with rvalid 5 cycles late
        set_dly(0, 0, 0, 0, 5);
        send(8'd5, 1'b0, 32'h100, 32'h0, 4'h0, 0, 1);
        wait_done();
        check("rd_latency", 64'(rise_cyc - hs_cyc), 64'd8);

        // awready lags wready by 3 cycles
        set_dly(3, 0, 0, 0, 0);
        b0 = b_count;
        send(8'd7, 1'b1, 32'h104, 32'h1234_5678, 4'b0101, 0, 1);
        @(negedge clk);
        @(negedge clk);
        check("w_drops_aw_holds", 64'({axi.awvalid, axi.wvalid}), 64'b10);
        wait_done();
        check("one_b_handshake", 64'(b_count - b0), 64'd1);

        // read that never completes
        set_dly(0, 0, 0, 0, 0);
        hang_r = 1;
        send(8'd9, 1'b0, 32'h108, 32'h0, 4'h0, 1, 1);
        wait_done();
        check("timeout_latency", 64'(rise_cyc - hs_cyc), 64'd17);
        check("rready_after_to", 64'(axi.rready), 64'd0);
        hang_r = 0;
        flush_req++;
        repeat (2) @(negedge clk);

        // response backpressure with a queued second request
        hold = 1;
        send(8'd4, 1'b0, 32'h104, 32'h0, 4'h0, 0, 1);
        fork
            send(8'd6, 1'b1, 32'h110, 32'hCAFE_F00D, 4'hF, 0, 1);
            begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (rsp_valid) check("req_ready_while_held", 64'(req_ready), 64'd0);
                end
                check("rsp_valid_held", 64'(rsp_valid), 64'd1);
                hold = 0;
            end
        join
        wait_done();

        // reset while waiting for B
        set_dly(0, 0, 6, 0, 0);
        send(8'd11, 1'b1, 32'h10C, 32'hFFFF_FFFF, 4'hF, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("bready_in_wr_resp", 64'(axi.bready), 64'd1);
        #1 res_n = 0;
        flush_req++;
        #1;
        check("valids_in_reset", 64'({axi.awvalid, axi.wvalid, axi.arvalid,
              axi.bready, axi.rready, rsp_valid, req_ready}), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 res_n = 1;
        set_dly(0, 0, 0, 0, 0);
        send(8'd13, 1'b0, 32'h10C, 32'h0, 4'h0, 0, 1);
        wait_done();

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            wait_done();
            set_dly($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
            rwe   = 1'($urandom_range(0, 1));
            raddr = ($urandom_range(0, 1) != 0 ? 32'h300 : 32'h100) +
                    32'(4 * $urandom_range(0, 7));
            send(8'($urandom), rwe, raddr, $urandom, 4'($urandom), 0, 1);
        end
        wait_done();

        check("b_total", 64'(b_count), 64'(exp_b));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
